// File: rtl/p2s_stream.sv
// p2s_stream: multi-lane parallel-to-serial transmitter for 74HC595-style shift-register chains.
// Optional macro P2S_CLEAR_EN: drives sclrn low during reset and for CLK_DIV cycles at the start of every frame.
module p2s_stream #(
    parameter int DATA_BITS = 16,
    parameter int CHANNELS  = 1,
    parameter int DIR       = 0,
    parameter int CLK_DIV   = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHANNELS*DATA_BITS-1:0] data,
    output logic                          sclk,
    output logic                          sclrn,
    output logic [CHANNELS-1:0]           sout,
    output logic                          sen,
    output logic                          busy,
    output logic                          done
);
    // state | meaning
    // IDLE  | waiting for a frame; sen high, in_ready high
    // CLEAR | sclrn low for CLK_DIV cycles before shifting (P2S_CLEAR_EN builds only)
    // SHIFT | one bit per sclk period, register shifts on sclk fall
    // LATCH | sclk low, last bit held for CLK_DIV cycles, then sen rises
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, CLEAR} state_t;

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
`ifdef P2S_CLEAR_EN
    localparam logic SCLRN_RST = 1'b0;
`else
    localparam logic SCLRN_RST = 1'b1;
`endif

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [DATA_BITS-1:0] shreg [CHANNELS];

    function automatic logic first_bit(input logic [DATA_BITS-1:0] w);
        return (DIR != 0) ? w[0] : w[DATA_BITS-1];
    endfunction

    function automatic logic [DATA_BITS-1:0] shift_word(input logic [DATA_BITS-1:0] w);
        return (DIR != 0) ? {1'b0, w[DATA_BITS-1:1]} : {w[DATA_BITS-2:0], 1'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            sclk     <= 1'b0;
            sout     <= '0;
            sen      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b0;
            sclrn    <= SCLRN_RST;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            for (int k = 0; k < CHANNELS; k++) shreg[k] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sen      <= 1'b1;
                    sclk     <= 1'b0;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                    sclrn    <= 1'b1;
                    if (in_valid && in_ready) begin
                        for (int k = 0; k < CHANNELS; k++) begin
                            shreg[k] <= data[k*DATA_BITS +: DATA_BITS];
                            sout[k]  <= first_bit(data[k*DATA_BITS +: DATA_BITS]);
                        end
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        sen      <= 1'b0;
                        div_cnt  <= DIV_LOAD;
                        bit_cnt  <= '0;
`ifdef P2S_CLEAR_EN
                        state    <= CLEAR;
                        sclrn    <= 1'b0;
`else
                        state    <= SHIFT;
`endif
                    end
                end
`ifdef P2S_CLEAR_EN
                CLEAR: begin
                    if (div_cnt == '0) begin
                        state   <= SHIFT;
                        sclrn   <= 1'b1;
                        div_cnt <= DIV_LOAD;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
`endif
                SHIFT: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else begin
                        div_cnt <= DIV_LOAD;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            // Falling sclk: advance to the next bit, or hold the last one into LATCH.
                            sclk <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                state <= LATCH;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                for (int k = 0; k < CHANNELS; k++) begin
                                    shreg[k] <= shift_word(shreg[k]);
                                    sout[k]  <= first_bit(shift_word(shreg[k]));
                                end
                            end
                        end
                    end
                end
                LATCH: begin
                    if (div_cnt == '0) begin
                        state    <= IDLE;
                        sen      <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        in_ready <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_p2s_stream.sv
// Scoreboard bench for p2s_stream: three configurations, directed frames checked by a negedge monitor.
module tb_p2s_stream;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic clk = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef P2S_CLEAR_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif

    logic        v0, v1, v2;
    logic [15:0] d0;
    logic [7:0]  d1;
    logic [11:0] d2;
    logic        r0, r1, r2, sc0, sc1, sc2, cl0, cl1, cl2, se0, se1, se2, b0, b1, b2, dn0, dn1, dn2;
    logic [0:0]  so0, so1;
    logic [2:0]  so2;

    p2s_stream dut0 (
        .clk(clk), .rstn(rstn), .in_valid(v0), .in_ready(r0), .data(d0), .sclk(sc0),
        .sclrn(cl0), .sout(so0), .sen(se0), .busy(b0), .done(dn0)
    );
    p2s_stream #(.DATA_BITS(8), .CHANNELS(1), .DIR(1), .CLK_DIV(1)) dut1 (
        .clk(clk), .rstn(rstn), .in_valid(v1), .in_ready(r1), .data(d1), .sclk(sc1),
        .sclrn(cl1), .sout(so1), .sen(se1), .busy(b1), .done(dn1)
    );
    p2s_stream #(.DATA_BITS(4), .CHANNELS(3), .DIR(0), .CLK_DIV(2)) dut2 (
        .clk(clk), .rstn(rstn), .in_valid(v2), .in_ready(r2), .data(d2), .sclk(sc2),
        .sclrn(cl2), .sout(so2), .sen(se2), .busy(b2), .done(dn2)
    );

    logic       vld [3];
    logic       rdy [3];
    logic       skl [3];
    logic       clr [3];
    logic       senx [3];
    logic       bsy [3];
    logic       dne [3];
    logic [2:0] so [3];

    assign vld[0] = v0;  assign vld[1] = v1;  assign vld[2] = v2;
    assign rdy[0] = r0;  assign rdy[1] = r1;  assign rdy[2] = r2;
    assign skl[0] = sc0; assign skl[1] = sc1; assign skl[2] = sc2;
    assign clr[0] = cl0; assign clr[1] = cl1; assign clr[2] = cl2;
    assign senx[0] = se0; assign senx[1] = se1; assign senx[2] = se2;
    assign bsy[0] = b0;  assign bsy[1] = b1;  assign bsy[2] = b2;
    assign dne[0] = dn0; assign dne[1] = dn1; assign dne[2] = dn2;
    assign so[0] = {2'b00, so0};
    assign so[1] = {2'b00, so1};
    assign so[2] = so2;

    typedef struct {
        int          inst;
        logic [47:0] bits;
    } exp_t;
    exp_t exp_q [$];
    exp_t e_mon;

    function automatic int db_of(int i);
        case (i)
            0: return 16;
            1: return 8;
            default: return 4;
        endcase
    endfunction

    function automatic int cd_of(int i);
        return (i == 1) ? 1 : 2;
    endfunction

    function automatic int lat_of(int i);
        return 2 * cd_of(i) * db_of(i) + cd_of(i) + CLR * cd_of(i);
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: collects bits at sclk rising edges and scores each frame when done pulses.
    logic       inframe [3];
    logic       psk [3];
    logic [2:0] pso [3];
    logic [15:0] col [3][3];
    int e0 [3];
    int nrise [3];
    int frise [3];
    int senlow [3];
    int clrlow [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rstn) begin
                inframe[i] = 1'b0;
            end else begin
                if (dne[i]) begin
                    if (!inframe[i] || exp_q.size() == 0) begin
                        chk($sformatf("unexpected_done_%0d", i), 1, 0);
                    end else begin
                        e_mon = exp_q.pop_front();
                        chk("done_inst", longint'(i), longint'(e_mon.inst));
                        chk($sformatf("frame_bits_%0d", i),
                            longint'({col[i][2], col[i][1], col[i][0]}), longint'(e_mon.bits));
                        chk($sformatf("done_latency_%0d", i), longint'(cyc - e0[i]), longint'(lat_of(i)));
                        chk($sformatf("sclk_rises_%0d", i), longint'(nrise[i]), longint'(db_of(i)));
                        chk($sformatf("first_rise_%0d", i), longint'(frise[i] - e0[i]),
                            longint'(cd_of(i) * (1 + CLR)));
                        chk($sformatf("sen_low_cycles_%0d", i), longint'(senlow[i]), longint'(lat_of(i)));
                        chk($sformatf("sclrn_low_cycles_%0d", i), longint'(clrlow[i]), longint'(CLR * cd_of(i)));
                        chk($sformatf("sen_at_done_%0d", i), longint'(senx[i]), 1);
                    end
                    inframe[i] = 1'b0;
                end
                if (inframe[i]) begin
                    if (!senx[i]) senlow[i]++;
                    if (!clr[i]) clrlow[i]++;
                    chk($sformatf("ready_low_in_frame_%0d", i), longint'(rdy[i]), 0);
                    if (skl[i] && !psk[i]) begin
                        nrise[i]++;
                        if (frise[i] < 0) frise[i] = cyc;
                        chk($sformatf("sout_stable_at_rise_%0d", i), longint'(so[i]), longint'(pso[i]));
                        for (int l = 0; l < 3; l++) col[i][l] = {col[i][l][14:0], so[i][l]};
                    end
                end
                if (vld[i] && rdy[i]) begin
                    e0[i]      = cyc + 1;
                    inframe[i] = 1'b1;
                    nrise[i]   = 0;
                    frise[i]   = -1;
                    senlow[i]  = 0;
                    clrlow[i]  = 0;
                    for (int l = 0; l < 3; l++) col[i][l] = '0;
                end
            end
            psk[i] = skl[i];
            pso[i] = so[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int i, logic v, logic [15:0] d);
        case (i)
            0: begin v0 = v; d0 = d; end
            1: begin v1 = v; d1 = d[7:0]; end
            default: begin v2 = v; d2 = d[11:0]; end
        endcase
    endtask

    task automatic wait_ready(int i, string name);
        int n = 0;
        while (!rdy[i] && n < 300) begin
            tick();
            n++;
        end
        chk(name, longint'(rdy[i]), 1);
    endtask

    task automatic send(int i, logic [15:0] d, logic [47:0] bits);
        exp_t e;
        e.inst = i;
        e.bits = bits;
        exp_q.push_back(e);
        drive(i, 1'b1, d);
        wait_ready(i, "accept_wait");
        tick();
        drive(i, 1'b0, d);
    endtask

    task automatic wait_idle(int i);
        int n = 0;
        while ((bsy[i] || !rdy[i]) && n < 500) begin
            tick();
            n++;
        end
        chk("idle_wait", longint'(bsy[i]), 0);
        tick();
        tick();
    endtask

    task automatic chk_reset_vals(int i, string tag);
        chk({tag, "_sclk"}, longint'(skl[i]), 0);
        chk({tag, "_sen"}, longint'(senx[i]), 1);
        chk({tag, "_sout"}, longint'(so[i]), 0);
        chk({tag, "_busy"}, longint'(bsy[i]), 0);
        chk({tag, "_done"}, longint'(dne[i]), 0);
        chk({tag, "_in_ready"}, longint'(rdy[i]), 0);
        chk({tag, "_sclrn"}, longint'(clr[i]), longint'(1 - CLR));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t eb;
        for (int i = 0; i < 3; i++) begin
            inframe[i] = 1'b0;
            frise[i]   = -1;
        end
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        d0 = '0;   d1 = '0;   d2 = '0;
        rstn = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) chk_reset_vals(i, "rst");
        rstn = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) chk("ready_after_rst", longint'(rdy[i]), 1);

        send(0, 16'hA5C3, 48'h0000_0000_A5C3);
        wait_idle(0);

        send(1, 16'h0001, 48'h0000_0000_0080);
        wait_idle(1);
        send(1, 16'h00B4, 48'h0000_0000_002D);
        wait_idle(1);

        send(2, 16'h0F0A, 48'h000F_0000_000A);
        wait_idle(2);
        send(2, 16'h05C3, 48'h0005_000C_0003);
        wait_idle(2);

        send(0, 16'h0000, 48'h0);
        wait_idle(0);

        eb.inst = 0; eb.bits = 48'hFFFF; exp_q.push_back(eb);
        eb.inst = 0; eb.bits = 48'h0001; exp_q.push_back(eb);
        drive(0, 1'b1, 16'hFFFF);
        wait_ready(0, "b2b_first");
        tick();
        drive(0, 1'b1, 16'h0001);
        tick();
        wait_ready(0, "b2b_second");
        chk("b2b_done_with_ready", longint'(dne[0]), 1);
        chk("b2b_sen_high", longint'(senx[0]), 1);
        tick();
        chk("b2b_sen_one_cycle", longint'(senx[0]), 0);
        drive(0, 1'b0, 16'h0);
        wait_idle(0);

        send(0, 16'h3C96, 48'h3C96);
        for (int k = 0; k < 20; k++) begin
            drive(0, 1'($urandom_range(0, 1)), 16'($urandom));
            tick();
            chk("ready_low_toggle", longint'(rdy[0]), 0);
        end
        drive(0, 1'b0, 16'h0);
        wait_idle(0);

        send(0, 16'h1234, 48'h1234);
        repeat (19) tick();
        rstn = 1'b0;
        tick();
        chk_reset_vals(0, "abort");
        exp_q.delete();
        tick();
        rstn = 1'b1;
        tick();
        chk("ready_after_abort", longint'(rdy[0]), 1);
        send(0, 16'h8001, 48'h8001);
        wait_idle(0);

        chk("queue_empty", longint'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
